// File: rtl/colour_sequence_gen.sv
// rtl/colour_sequence_gen.sv - random colour generator with sequence memory and timed replay
//
// Purpose:
//   A free-running Galois LFSR is sampled on gen_req and mapped to a 3-bit RGB
//   colour that is appended to a small sequence buffer. replay_req plays the
//   stored sequence back as SHOW_CYC-cycle colour pulses separated by GAP_CYC
//   blank cycles.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous reset, active-high
//   clear        in   synchronous clear of the sequence, FSM back to IDLE
//   gen_req      in   append one random colour (strobe)
//   replay_req   in   start playback of the stored sequence (strobe)
//   col_out      out  RGB colour {R,G,B}, 000 when not valid
//   col_valid    out  col_out is meaningful this cycle
//   replay_busy  out  high while showing or gapping
//   replay_done  out  one-cycle pulse at end of playback
//   overflow     out  one-cycle pulse when gen_req is refused (buffer full)
//   seq_len      out  number of stored colours, 0..DEPTH
//   full         out  seq_len == DEPTH

module colour_sequence_gen #(
  parameter int                LFSR_W   = 8,
  parameter logic [LFSR_W-1:0] TAPS     = 8'hB8,
  parameter logic [LFSR_W-1:0] SEED     = 8'hA5,
  parameter int                COL_BITS = 2,
  parameter int                DEPTH    = 16,
  parameter int                SHOW_CYC = 4,
  parameter int                GAP_CYC  = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     gen_req,
  input  logic                     replay_req,
  output logic [2:0]               col_out,
  output logic                     col_valid,
  output logic                     replay_busy,
  output logic                     replay_done,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   seq_len,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LEN_W = PTR_W + 1;
  localparam int CNT_W = $clog2(SHOW_CYC + GAP_CYC) + 1;

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [LEN_W-1:0] LEN_FULL  = LEN_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  function automatic logic [2:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    palette = 3'b100;
      3'd1:    palette = 3'b001;
      3'd2:    palette = 3'b110;
      3'd3:    palette = 3'b010;
      3'd4:    palette = 3'b101;
      3'd5:    palette = 3'b011;
      3'd6:    palette = 3'b111;
      default: palette = 3'b000;
    endcase
  endfunction

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [PTR_W-1:0]  rd_ptr, rd_ptr_d;
  logic [LEN_W-1:0]  seq_len_d;
  logic [LFSR_W-1:0] lfsr, lfsr_d;
  logic [2:0]        col_d;
  logic              valid_d, busy_d, done_d, ovf_d, full_d;
  logic              we;
  logic [2:0]        mem [DEPTH];

  logic [COL_BITS-1:0] idx;
  logic [2:0]          gen_colour;

  assign idx        = lfsr[LFSR_W-1 -: COL_BITS];
  assign gen_colour = palette(3'(idx));

  // LFSR runs every cycle; an all-zero state would lock up, so it reloads SEED.
  always_comb begin
    if (lfsr == '0)
      lfsr_d = SEED;
    else
      lfsr_d = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
  end

  // Outputs are computed here as next-cycle values and registered below, so
  // they line up with the state they describe.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    rd_ptr_d  = rd_ptr;
    seq_len_d = seq_len;
    col_d     = 3'b000;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    ovf_d     = 1'b0;
    we        = 1'b0;

    if (clear) begin
      state_d   = IDLE;
      cnt_d     = '0;
      rd_ptr_d  = '0;
      seq_len_d = '0;
    end else begin
      case (state)
        IDLE: begin
          if (gen_req) begin
            // gen_req outranks replay_req; a simultaneous replay is dropped.
            if (!full) begin
              we        = !reset;
              seq_len_d = seq_len + LEN_W'(1);
              col_d     = gen_colour;
              valid_d   = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end else if (replay_req) begin
            if (seq_len == '0) begin
              done_d = 1'b1;
            end else begin
              state_d  = SHOW;
              cnt_d    = '0;
              rd_ptr_d = '0;
              col_d    = mem[0];
              valid_d  = 1'b1;
              busy_d   = 1'b1;
            end
          end
        end
        SHOW: begin
          busy_d = 1'b1;
          if (cnt == SHOW_LAST) begin
            state_d = GAP;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt + CNT_W'(1);
            col_d   = mem[rd_ptr];
            valid_d = 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt_d = '0;
            if ({1'b0, rd_ptr} == seq_len - LEN_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d  = SHOW;
              rd_ptr_d = rd_ptr + PTR_W'(1);
              col_d    = mem[rd_ptr + PTR_W'(1)];
              valid_d  = 1'b1;
              busy_d   = 1'b1;
            end
          end else begin
            cnt_d  = cnt + CNT_W'(1);
            busy_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    full_d = (seq_len_d == LEN_FULL);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rd_ptr      <= '0;
      seq_len     <= '0;
      lfsr        <= SEED;
      col_out     <= 3'b000;
      col_valid   <= 1'b0;
      replay_busy <= 1'b0;
      replay_done <= 1'b0;
      overflow    <= 1'b0;
      full        <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      rd_ptr      <= rd_ptr_d;
      seq_len     <= seq_len_d;
      lfsr        <= lfsr_d;
      col_out     <= col_d;
      col_valid   <= valid_d;
      replay_busy <= busy_d;
      replay_done <= done_d;
      overflow    <= ovf_d;
      full        <= full_d;
    end
  end

  // Sequence RAM has no reset.
  always_ff @(posedge clock) begin
    if (we)
      mem[seq_len[PTR_W-1:0]] <= gen_colour;
  end

endmodule

// File: tb/tb_colour_sequence_gen.sv
// tb/tb_colour_sequence_gen.sv - directed self-checking bench for colour_sequence_gen

module tb_colour_sequence_gen;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       gen_req = 1'b0;
  logic       replay_req = 1'b0;
  logic [2:0] col_out;
  logic       col_valid;
  logic       replay_busy;
  logic       replay_done;
  logic       overflow;
  logic [4:0] seq_len;
  logic       full;

  int errors = 0;
  int checks = 0;

  colour_sequence_gen dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .gen_req     (gen_req),
    .replay_req  (replay_req),
    .col_out     (col_out),
    .col_valid   (col_valid),
    .replay_busy (replay_busy),
    .replay_done (replay_done),
    .overflow    (overflow),
    .seq_len     (seq_len),
    .full        (full)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; returns 1 ns after the edge so outputs are settled
  // and new inputs are set well before the next edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // {busy, valid, col, done}
  function automatic logic [5:0] pack(input logic b, input logic v, input logic [2:0] c, input logic d);
    return {b, v, c, d};
  endfunction

  logic [2:0] exp_col [3];

  initial begin
    // Stored order from seed A5: A5 -> yellow, EA -> green, 75 -> blue
    exp_col[0] = 3'b110;
    exp_col[1] = 3'b010;
    exp_col[2] = 3'b001;

    tick();
    tick();
    check("rst_seq_len", 32'(seq_len), 0);
    check("rst_valid",   32'(col_valid), 0);
    check("rst_col",     32'(col_out), 0);
    check("rst_full",    32'(full), 0);
    check("rst_busy_done_ovf", {replay_busy, replay_done, overflow}, 0);

    // Release reset with gen_req set: first edge samples lfsr=A5
    reset   = 1'b0;
    gen_req = 1'b1;
    tick();
    check("gen1_col",   32'(col_out), 32'b110);
    check("gen1_valid", 32'(col_valid), 1);
    check("gen1_len",   32'(seq_len), 1);
    tick();
    check("gen2_col",   32'(col_out), 32'b010);
    check("gen2_len",   32'(seq_len), 2);
    tick();
    check("gen3_col",   32'(col_out), 32'b001);
    check("gen3_len",   32'(seq_len), 3);
    gen_req = 1'b0;
    tick();
    check("gen_valid_drop", 32'(col_valid), 0);

    // Replay of three colours: 3 x (4 shown, 2 blank), then done pulse
    replay_req = 1'b1;
    tick();
    replay_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 6; k++) begin
        if (k < 4)
          check($sformatf("replay_c%0d_show%0d", c, k), 32'({replay_busy, col_valid, col_out, replay_done}),
                32'(pack(1'b1, 1'b1, exp_col[c], 1'b0)));
        else
          check($sformatf("replay_c%0d_gap%0d", c, k - 4), 32'({replay_busy, col_valid, col_out, replay_done}),
                32'(pack(1'b1, 1'b0, 3'b000, 1'b0)));
        // gen_req during replay must be ignored without overflow
        gen_req = (c == 0 && k == 1);
        if (c == 0 && k == 2)
          check("replay_no_ovf", 32'(overflow), 0);
        tick();
      end
    end
    check("replay_end", 32'({replay_busy, col_valid, col_out, replay_done}), 32'(pack(1'b0, 1'b0, 3'b000, 1'b1)));
    check("replay_len_kept", 32'(seq_len), 3);
    tick();
    check("replay_done_once", 32'(replay_done), 0);

    // gen_req and replay_req together: append only
    gen_req    = 1'b1;
    replay_req = 1'b1;
    tick();
    gen_req    = 1'b0;
    replay_req = 1'b0;
    check("both_valid", 32'(col_valid), 1);
    check("both_len",   32'(seq_len), 4);
    check("both_busy",  32'(replay_busy), 0);
    tick();
    check("both_no_show", 32'({replay_busy, col_valid}), 0);

    // clear, then replay of an empty sequence
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_len", 32'(seq_len), 0);
    replay_req = 1'b1;
    tick();
    replay_req = 1'b0;
    check("empty_done", 32'({replay_busy, replay_done}), 32'b01);
    tick();
    check("empty_after", 32'({replay_busy, replay_done}), 0);

    // clear during SHOW
    gen_req = 1'b1;
    tick();
    tick();
    gen_req    = 1'b0;
    replay_req = 1'b1;
    tick();
    replay_req = 1'b0;
    check("pre_clear_busy", 32'(replay_busy), 1);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_show_state", 32'({replay_busy, col_valid, replay_done}), 0);
    check("clr_show_len",   32'(seq_len), 0);
    tick();
    check("clr_show_nodone", 32'({replay_busy, replay_done}), 0);

    // Fill to 16 then one refused gen
    gen_req = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    check("fill_len",  32'(seq_len), 16);
    check("fill_full", 32'(full), 1);
    tick();
    gen_req = 1'b0;
    check("ovf_pulse", 32'(overflow), 1);
    check("ovf_valid", 32'(col_valid), 0);
    check("ovf_len",   32'(seq_len), 16);
    tick();
    check("ovf_one_cycle", 32'(overflow), 0);
    check("ovf_full_kept", 32'(full), 1);

    // Async reset mid-GAP: 4 SHOW samples then first GAP sample
    replay_req = 1'b1;
    tick();
    replay_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("gap_reached", 32'({replay_busy, col_valid}), 32'b10);
    #2;
    reset = 1'b1;
    #1;
    check("arst_outputs", 32'({replay_busy, col_valid, col_out, replay_done, overflow, full}), 0);
    check("arst_len", 32'(seq_len), 0);
    tick();
    reset = 1'b0;
    tick();
    check("arst_after", 32'({replay_busy, replay_done, col_valid}), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
